muldiv_seq_unit: RTL and testbench
==================================

// Module: muldiv_seq_unit
// PURPOSE
//  Multi-cycle RV32M execution unit downstream of the ALU control stage. It consumes the
//  5-bit ALU selection for M-type ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) plus two
//  32-bit operands, and returns one 32-bit result. Radix-2 iterative: one bit per cycle.
//  Asserts busy so the hazard/stall logic freezes the pipeline until done.
// PARAMETERS
//  XLEN      32  operand/result width; only 32 is supported
//  ITER_CNT  32  iterations per mul/div; counter width is $clog2(ITER_CNT)+1
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      request; sampled only in IDLE or DONE
//  flush      in   1      abort any in-flight op (branch/exception kill)
//  alu_sel    in   5      M-op code (`ALU_MUL..`ALU_REMU from defines.v)
//  op_a       in   32     rs1 value (dividend/multiplicand)
//  op_b       in   32     rs2 value (divisor/multiplier)
//  busy       out  1      high in CALC and FIX
//  done       out  1      one-cycle pulse; result valid while high
//  result     out  32     final value; holds until the next accepted start
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, busy=0, done=0, result=0, all internal regs=0.
//  FSM: IDLE -start-> CALC | CALC -cnt==ITER_CNT-1-> FIX | FIX -> DONE |
//       DONE -start-> CALC, else -> IDLE. flush in any state -> IDLE with done=0.
//  Accept at edge E0: latch alu_sel, abs(op_a), abs(op_b), and result sign. Signed for MULH,
//   DIV, REM. MULHSU: a signed, b unsigned. Others unsigned. Clear counter.
//  Latency: normal ops 32 CALC + 1 FIX -> done high in the cycle after edge E0+33. Busy high
//   in cycles after E0..E0+32.
//  MUL family: 64-bit acc, shift-add on LSB of multiplier. In FIX, negate the 64-bit product
//   if the sign flag is set. MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32].
//  DIV family: restoring division; 33-bit partial remainder; one quotient bit per cycle.
//   In FIX, negate the quotient if sign(a)^sign(b), and the remainder if sign(a).
//   DIV/DIVU return the quotient; REM/REMU return the remainder.
//  Divide by zero (op_b==0): skip CALC (IDLE/DONE -> FIX). done high in the cycle after edge
//   E0+1. Quotient=32'hFFFF_FFFF; remainder=op_a.
//  Signed overflow (DIV/REM, op_a=32'h8000_0000, op_b=32'hFFFF_FFFF): same fast path.
//   Quotient=32'h8000_0000; remainder=0.
//  abs(32'h8000_0000) is held as the 33-bit value 2^31; no overflow.
//  start while busy: ignored. Not queued, no error.
//  start in the DONE cycle: accepted (back-to-back issue, zero bubble).
//  flush and start in the same cycle: flush wins. Go to IDLE, drop the request.
//  alu_sel not an M op when start: treated as MUL. The issuer must not do this.
//  result updates only on the FIX->DONE edge. done is never high for two consecutive cycles
//   unless two ops complete back-to-back.
// STRUCTURE
//  Shared: `ALU_MUL..`ALU_REMU and new state localparams MDU_IDLE/CALC/FIX/DONE go in
//   defines.v. Do not hard-code opcode values locally.
//  Sub-module: muldiv_step, combinational single iteration. Inputs: mode, acc, operand.
//   Outputs: next acc/partial remainder and quotient bit. Instantiated once. The FSM,
//   counter and sign fix stay in muldiv_seq_unit.
// TESTING
//  MUL 7*-3: done on cycle 34, result=32'hFFFF_FFEB. MULHU FFFF_FFFF^2 -> 32'hFFFF_FFFE.
//  MULH 8000_0000*8000_0000 -> 32'h4000_0000. MULHSU FFFF_FFFF*2 -> 32'hFFFF_FFFF.
//  DIV -7/2 -> FFFF_FFFD; REM -7/2 -> FFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIV 5/0 -> FFFF_FFFF with done 2 cycles after start; REM 5/0 -> 5;
//   DIV 8000_0000/FFFF_FFFF -> 8000_0000; REM same operands -> 0.
//  Back-to-back: second start in the done cycle gets the correct result 34 cycles later.
//   A start pulsed mid-CALC is ignored; busy is never dropped early.
//  flush at CALC cycle 10 -> IDLE next cycle, no done, result unchanged.
//   rst mid-CALC -> busy=0, done=0, result=0 immediately.

Source files
------------

// File: rtl/muldiv_seq_unit_pkg.sv
// rtl/muldiv_seq_unit_pkg.sv - shared M-op codes, MDU state encoding and op-class helpers
package muldiv_seq_unit_pkg;

  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  function automatic logic is_m_op(input logic [4:0] sel);
    return (sel >= ALU_MUL) && (sel <= ALU_REMU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] sel);
    return (sel >= ALU_DIV) && (sel <= ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
module muldiv_step (
  input  logic        div_mode,
  input  logic [64:0] acc_i,
  input  logic [32:0] operand_i,
  output logic [64:0] acc_o,
  output logic        q_bit_o
);

  logic [33:0] sum;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic [32:0] rem_next;

  // acc holds {hi[32:0], lo[31:0]}: multiplier or quotient bits live in lo
  always_comb begin
    sum      = {1'b0, acc_i[64:32]} + (acc_i[0] ? {1'b0, operand_i} : 34'd0);
    shifted  = {acc_i[63:32], acc_i[31]};
    diff     = {1'b0, shifted} - {1'b0, operand_i};
    q_bit_o  = 1'b0;
    rem_next = shifted;
    acc_o    = {sum, acc_i[31:1]};
    if (div_mode) begin
      q_bit_o  = ~diff[33];
      rem_next = diff[33] ? shifted : diff[32:0];
      acc_o    = {rem_next, acc_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq_unit.sv
// rtl/muldiv_seq_unit.sv - multi-cycle RV32M multiply/divide unit, one bit per cycle
module muldiv_seq_unit
  import muldiv_seq_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ITER_CNT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(ITER_CNT) + 1;

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d, fast_q, fast_d;
  logic [64:0]       acc_q, acc_d;
  logic [32:0]       opnd_q, opnd_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [4:0]        sel_op;
  logic              sgn_a, sgn_b, div_zero, div_ovf;
  logic [32:0]       abs_a, abs_b;
  logic [63:0]       prod;
  logic [31:0]       quot, rem;
  logic [64:0]       step_acc;
  logic              step_q;

  muldiv_step u_step (
    .div_mode  (is_div_op(op_q)),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (step_acc),
    .q_bit_o   (step_q)
  );

  // Operand conditioning at accept; sign-extending to 33 bits keeps abs(INT_MIN) = 2^31 exact
  always_comb begin
    sel_op   = is_m_op(alu_sel) ? alu_sel : ALU_MUL;
    sgn_a    = op_a[31] && (sel_op == ALU_MULH || sel_op == ALU_MULHSU ||
                            sel_op == ALU_DIV  || sel_op == ALU_REM);
    sgn_b    = op_b[31] && (sel_op == ALU_MULH || sel_op == ALU_DIV || sel_op == ALU_REM);
    abs_a    = sgn_a ? (~{1'b1, op_a} + 33'd1) : {1'b0, op_a};
    abs_b    = sgn_b ? (~{1'b1, op_b} + 33'd1) : {1'b0, op_b};
    div_zero = (op_b == 32'd0);
    div_ovf  = (sel_op == ALU_DIV || sel_op == ALU_REM) &&
               (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  end

  // Sign fix-up; fast-path results are preloaded already final
  always_comb begin
    prod = (sa_q ^ sb_q) ? (~acc_q[63:0] + 64'd1) : acc_q[63:0];
    quot = (!fast_q && (sa_q ^ sb_q)) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem  = (!fast_q && sa_q) ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    fast_d   = fast_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (flush) begin
      state_d = MDU_IDLE;
    end else begin
      case (state_q)
        MDU_IDLE, MDU_DONE: begin
          state_d = MDU_IDLE;
          if (start) begin
            op_d   = sel_op;
            sa_d   = sgn_a;
            sb_d   = sgn_b;
            cnt_d  = '0;
            fast_d = 1'b0;
            if (is_div_op(sel_op) && (div_zero || div_ovf)) begin
              fast_d  = 1'b1;
              acc_d   = div_zero ? {1'b0, op_a, 32'hFFFF_FFFF} : {33'd0, 32'h8000_0000};
              state_d = MDU_FIX;
            end else begin
              acc_d   = is_div_op(sel_op) ? {33'd0, abs_a[31:0]} : {33'd0, abs_b[31:0]};
              opnd_d  = is_div_op(sel_op) ? abs_b : abs_a;
              state_d = MDU_CALC;
            end
          end
        end
        MDU_CALC: begin
          acc_d = {step_acc[64:1], step_acc[0] | step_q};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER_CNT - 1)) state_d = MDU_FIX;
        end
        MDU_FIX: begin
          case (op_q)
            ALU_MUL:                        result_d = prod[31:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: result_d = prod[63:32];
            ALU_DIV, ALU_DIVU:              result_d = quot;
            default:                        result_d = rem;
          endcase
          done_d  = 1'b1;
          state_d = MDU_DONE;
        end
        default: state_d = MDU_IDLE;
      endcase
    end
    busy_d = (state_d == MDU_CALC) || (state_d == MDU_FIX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      fast_q   <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      fast_q   <= fast_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// tb/tb_muldiv_seq_unit.sv - scoreboard bench for muldiv_seq_unit with directed vectors
module tb_muldiv_seq_unit;
  import muldiv_seq_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  alu_sel = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] last_res = '0;

  muldiv_seq_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .flush   (flush),
    .alu_sel (alu_sel),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit fast, input bit track);
    exp_t e;
    alu_sel = sel;
    op_a    = a;
    op_b    = b;
    start   = 1'b1;
    if (track) begin
      e.res = exp;
      e.cyc = cyc + 1 + (fast ? 1 : 33);
      sb.push_back(e);
      last_res = exp;
    end
  endtask

  task automatic wait_done(input int pulse_at);
    bit drop = 0;
    bit got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start = (i == pulse_at);
      if (i == pulse_at) op_a = $urandom;
      if (done) begin
        got = 1;
        break;
      end
      if (!busy) drop = 1;
    end
    start = 1'b0;
    check("busy_hold", 32'(drop), 32'd0);
    check("done_seen", 32'(got), 32'd1);
  endtask

  task automatic run(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input bit fast);
    issue(sel, a, b, exp, fast, 1);
    wait_done(-1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(ALU_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run(ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run(ALU_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 0);
    run(ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
    run(ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
    run(ALU_DIVU,   32'd100,       32'd7,         32'd14,        0);
    run(ALU_REMU,   32'd100,       32'd7,         32'd2,         0);
    run(ALU_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
    run(ALU_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         0);
    run(ALU_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 0);
    run(ALU_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run(ALU_REM,    32'd5,         32'd0,         32'd5,         1);
    run(ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run(ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // back-to-back: second start lands in the DONE cycle
    run(ALU_MUL, 32'd12, 32'd11, 32'd132, 0);
    issue(ALU_DIVU, 32'd1000, 32'd10, 32'd100, 0, 1);
    wait_done(-1);

    // stray start mid-CALC must be ignored
    issue(ALU_MULHU, 32'h0001_0000, 32'h0003_0000, 32'd3, 0, 1);
    wait_done(5);
    repeat (40) @(negedge clk);

    // flush at CALC cycle 10
    issue(ALU_MUL, 32'd9, 32'd9, 32'd0, 0, 0);
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_result", result, last_res);
    repeat (40) @(negedge clk);

    // flush wins over a simultaneous start
    alu_sel = ALU_MUL;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("flush_start_busy2", 32'(busy), 32'd0);

    // async reset mid-CALC
    issue(ALU_DIVU, 32'd77, 32'd3, 32'd0, 0, 0);
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(ALU_MUL, 32'd6, 32'd7, 32'd42, 0);
    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
